// File: rtl/sqrt_rom_ctrl.sv
// Range-reducing driver and rescaler for a 256x16 registered sqrt ROM (sqrt(x)*2^11.5).
// Optional build macro SQRT_ROUND_EN selects round-to-nearest ROM indexing instead of truncation.
module sqrt_rom_ctrl #(
    parameter  int unsigned W_DIN  = 32,
    parameter  int unsigned W_ROM  = 16,
    parameter  int unsigned W_ADDR = 8,
    localparam int unsigned W_DOUT = W_ROM + (W_DIN - 8) / 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_DIN-1:0]  din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              rom_ena,
    output logic [W_ADDR-1:0] rom_addr,
    input  logic [W_ROM-1:0]  rom_data,
    output logic [W_DOUT-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready
);

    localparam int unsigned H_MAX = (W_DIN - 8) / 2;
    localparam int unsigned W_H   = (H_MAX > 0) ? $clog2(H_MAX + 1) : 1;

    logic              adv;
    logic              found;
    logic [W_H-1:0]    h_d;
    logic [W_H:0]      sh_amt;
    logic [W_ADDR-1:0] idx_trunc;
    logic [W_ADDR-1:0] idx_d;

    logic              s1_valid_q;
    logic [W_ADDR-1:0] s1_idx_q;
    logic [W_H-1:0]    s1_h_q;
    logic              s2_valid_q;
    logic [W_H-1:0]    s2_h_q;
    logic              s3_valid_q;
    logic [W_DOUT-1:0] s3_dout_q;

`ifdef SQRT_ROUND_EN
    logic              rbit;
    logic [W_ADDR:0]   idx_sum;
`endif

    assign adv       = !s3_valid_q || dout_ready;
    assign din_ready = adv;
    // ROM only reads when S1 moves into S2; otherwise it holds the word S2 is waiting on.
    assign rom_ena   = adv && s1_valid_q;
    assign rom_addr  = s1_idx_q;
    assign dout      = s3_dout_q;
    assign dout_valid = s3_valid_q;

    // Smallest even shift that brings the operand under 2^W_ADDR.
    always_comb begin
        h_d   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k <= H_MAX; k++) begin
            if (!found && (((din >> (2 * k)) >> W_ADDR) == W_DIN'(0))) begin
                h_d   = W_H'(k);
                found = 1'b1;
            end
        end
        sh_amt    = {h_d, 1'b0};
        idx_trunc = W_ADDR'(din >> sh_amt);
`ifdef SQRT_ROUND_EN
        rbit    = (sh_amt != '0) ? |(din & (W_DIN'(1) << (sh_amt - 1'b1))) : 1'b0;
        idx_sum = {1'b0, idx_trunc} + (W_ADDR + 1)'(rbit);
        idx_d   = idx_sum[W_ADDR] ? '1 : idx_sum[W_ADDR-1:0];
`else
        idx_d   = idx_trunc;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_h_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_h_q     <= '0;
            s3_valid_q <= 1'b0;
            s3_dout_q  <= '0;
        end else if (adv) begin
            s1_valid_q <= din_valid;
            if (din_valid) begin
                s1_idx_q <= idx_d;
                s1_h_q   <= h_d;
            end
            s2_valid_q <= s1_valid_q;
            s2_h_q     <= s1_h_q;
            s3_valid_q <= s2_valid_q;
            s3_dout_q  <= W_DOUT'(rom_data) << s2_h_q;
        end
    end

endmodule

// File: tb/tb_sqrt_rom_ctrl.sv
// Directed bench for sqrt_rom_ctrl with a registered 256x16 ROM model holding floor(sqrt(i*2^23)).
module tb_sqrt_rom_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        rom_ena;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [27:0] dout;
    logic        dout_valid;
    logic        dout_ready;

    int total = 0;
    int bad   = 0;

    sqrt_rom_ctrl #(.W_DIN(32), .W_ROM(16), .W_ADDR(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .rom_ena    (rom_ena),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] isqrt(input logic [63:0] v);
        logic [63:0] r;
        r = 0;
        for (int b = 31; b >= 0; b--) begin
            if ((r | (64'd1 << b)) * (r | (64'd1 << b)) <= v) r = r | (64'd1 << b);
        end
        return r[15:0];
    endfunction

    always @(posedge clk) begin
        if (rom_ena) rom_data <= isqrt({56'd0, rom_addr} << 23);
    end

    task automatic test_reset;
        rst = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid got=%b want=0", dout_valid); end
        total++; if (dout !== 28'h0) begin bad++; $display("FAIL reset_dout got=%h want=0", dout); end
        total++; if (rom_addr !== 8'h0) begin bad++; $display("FAIL reset_rom_addr got=%h want=0", rom_addr); end
        total++; if (rom_ena !== 1'b0) begin bad++; $display("FAIL reset_rom_ena got=%b want=0", rom_ena); end
        total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL reset_din_ready got=%b want=1", din_ready); end
        rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // Single operand through an idle pipeline: checks ROM index, 3-cycle latency and result.
    task automatic run_one(input logic [31:0] x, input logic [27:0] exp_dout,
                           input logic [7:0] exp_addr, input string name);
        int lat;
        int w;
        @(posedge clk); #1;
        din = x; din_valid = 1'b1; dout_ready = 1'b1;
        w = 0;
        while (!din_ready && w < 10) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        din_valid = 1'b0;
        lat = 1;
        total++; if (rom_addr !== exp_addr) begin bad++; $display("FAIL %s_addr got=%0d want=%0d", name, rom_addr, exp_addr); end
        total++; if (rom_ena !== 1'b1) begin bad++; $display("FAIL %s_rom_ena got=%b want=1", name, rom_ena); end
        while (!dout_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        total++; if (lat != 3) begin bad++; $display("FAIL %s_latency got=%0d want=3", name, lat); end
        total++; if (dout !== exp_dout) begin bad++; $display("FAIL %s_dout got=%h want=%h", name, dout, exp_dout); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        run_one(32'd4,        28'h00016a0, 8'd4,   "x4");
        run_one(32'd256,      28'h000b504, 8'd64,  "x256");
        run_one(32'd0,        28'h0000000, 8'd0,   "x0");
        run_one(32'hFFFFFFFF, 28'hb4aa000, 8'd255, "xmax");
    endtask

    task automatic test_rounding;
`ifdef SQRT_ROUND_EN
        run_one(32'd999, 28'h00165c4, 8'd250, "x999");
`else
        run_one(32'd999, 28'h001650c, 8'd249, "x999");
`endif
        run_one(32'd1022, 28'h0016954, 8'd255, "x1022");
    endtask

    task automatic test_back_to_back;
        logic [31:0] xs [4];
        logic [27:0] ex [4];
        int in_ptr, out_ptr, stall_cnt, cyc;
        logic stalled;
        xs[0] = 32'd4;  xs[1] = 32'd16;  xs[2] = 32'd64;  xs[3] = 32'd256;
        ex[0] = 28'h00016a0; ex[1] = 28'h0002d41; ex[2] = 28'h0005a82; ex[3] = 28'h000b504;
        in_ptr = 0; out_ptr = 0; stall_cnt = 0; cyc = 0;
        @(posedge clk); #1;
        while (out_ptr < 4 && cyc < 40) begin
            din_valid = (in_ptr < 4);
            din       = (in_ptr < 4) ? xs[in_ptr] : 32'd0;
            stalled   = dout_valid && (out_ptr == 1) && (stall_cnt < 5);
            dout_ready = !stalled;
            #1;
            if (stalled) begin
                stall_cnt++;
                total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL stall_din_ready got=%b want=0", din_ready); end
                total++; if (rom_ena !== 1'b0) begin bad++; $display("FAIL stall_rom_ena got=%b want=0", rom_ena); end
                total++; if (dout !== ex[1]) begin bad++; $display("FAIL stall_dout got=%h want=%h", dout, ex[1]); end
            end
            if (din_valid && din_ready) in_ptr++;
            if (dout_valid && dout_ready) begin
                total++; if (dout !== ex[out_ptr]) begin bad++; $display("FAIL stream_out%0d got=%h want=%h", out_ptr, dout, ex[out_ptr]); end
                out_ptr++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        din_valid = 1'b0; dout_ready = 1'b1;
        total++; if (out_ptr != 4) begin bad++; $display("FAIL stream_count got=%0d want=4", out_ptr); end
        total++; if (stall_cnt != 5) begin bad++; $display("FAIL stream_stall_cycles got=%0d want=5", stall_cnt); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_flush;
        int seen;
        @(posedge clk); #1;
        dout_ready = 1'b1;
        din_valid = 1'b1; din = 32'd4;
        @(posedge clk); #1; din = 32'd16;
        @(posedge clk); #1; din = 32'd64;
        @(posedge clk); #1; din_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL flush_dout_valid got=%b want=0", dout_valid); end
        total++; if (dout !== 28'h0) begin bad++; $display("FAIL flush_dout got=%h want=0", dout); end
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (dout_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL flush_stale got=%0d want=0", seen); end
        run_one(32'd9, 28'h00021f0, 8'd9, "x9_after_reset");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_rounding;
        test_back_to_back;
        test_reset_flush;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
